// File: rtl/if_id_queue_pkg.sv
// IF/ID queue shared definitions.
// Default geometry and the queued entry layout.
package if_id_queue_pkg;

  localparam int IQ_DEPTH = 4;
  localparam int IQ_WIDTH = 32;

  typedef struct packed {
    logic [IQ_WIDTH-1:0] pc;
    logic [IQ_WIDTH-1:0] instruction;
  } if_id_t;

endpackage

// File: rtl/if_queue_mem.sv
// IF/ID queue storage: register array,
// synchronous write, asynchronous read, no reset.
module if_queue_mem #(
  parameter int DEPTH = 4,
  parameter int EW    = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wAddr,
  input  logic [EW-1:0]            wData,
  input  logic [$clog2(DEPTH)-1:0] rAddr,
  output logic [EW-1:0]            rData
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wAddr] <= wData;
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: pointers, occupancy
// and handshakes around if_queue_mem.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = IQ_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instruction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] headEntry;

  assign out_valid = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case (1'b1)
        push & ~pop: count <= count + CW'(1);
        pop & ~push: count <= count - CW'(1);
        default:     count <= count;
      endcase
    end
  end

  // Flush drops the in-flight entry, so keep it out of storage too.
  if_queue_mem #(
    .DEPTH(DEPTH),
    .EW   (2*WIDTH)
  ) uMem (
    .clk  (clk),
    .we   (push & ~flush),
    .wAddr(tail),
    .wData({in_pc, in_instruction}),
    .rAddr(head),
    .rData(headEntry)
  );

  assign out_pc          = headEntry[2*WIDTH-1:WIDTH];
  assign out_instruction = headEntry[WIDTH-1:0];

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed
// scenarios plus random traffic against a queue model.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_instruction;
  logic             in_ready;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instruction;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  if_id_t model[$];
  if_id_t expQ[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_instruction (in_instruction),
    .in_ready       (in_ready),
    .flush          (flush),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instruction(out_instruction),
    .count          (count)
  );

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkState(string tag);
    chk({tag, "_count"}, longint'(count), longint'(model.size()));
    chk({tag, "_out_valid"}, longint'(out_valid), longint'(model.size() != 0));
    chk({tag, "_in_ready"}, longint'(in_ready), longint'(model.size() != DEPTH));
  endtask

  // One clock of stimulus; the model reflects the state after the coming edge.
  task automatic step(bit iv, logic [31:0] pc, logic [31:0] ins,
                      bit ordy, bit fl, string tag);
    bit doPush;
    bit doPop;
    if_id_t e;
    @(negedge clk);
    chkState(tag);
    in_valid       = iv;
    in_pc          = pc;
    in_instruction = ins;
    out_ready      = ordy;
    flush          = fl;
    doPush = iv && (model.size() < DEPTH);
    doPop  = ordy && (model.size() > 0);
    e.pc = pc;
    e.instruction = ins;
    if (doPop) expQ.push_back(model[0]);
    if (fl) model.delete();
    else begin
      if (doPop) void'(model.pop_front());
      if (doPush) model.push_back(e);
    end
  endtask

  // Monitor: every accepted pop must match the next expected entry.
  initial begin
    if_id_t got;
    if_id_t exp;
    forever begin
      @(negedge clk);
      #3;
      if (rst && out_valid && out_ready) begin
        got.pc = out_pc;
        got.instruction = out_instruction;
        if (expQ.size() == 0) begin
          chk("unexpected_pop", longint'(got), -1);
        end else begin
          exp = expQ.pop_front();
          chk("pop_entry", longint'(got), longint'(exp));
        end
      end
    end
  end

  initial begin
    logic [2*WIDTH-1:0] m0;
    rst = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_instruction = '0;
    out_ready = 1'b0;
    flush = 1'b0;
    #12;
    chk("reset_count", longint'(count), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;

    // basic flow
    step(1, 32'd4, 32'hE3A01005, 0, 0, "basic_push");
    step(0, 0, 0, 0, 0, "basic_after");
    chk("basic_pc", longint'(out_pc), 4);
    chk("basic_instr", longint'(out_instruction), 32'hE3A01005);
    step(0, 0, 0, 1, 0, "basic_pop");

    // fill, overflow attempt, drain
    for (int i = 1; i <= 4; i++)
      step(1, 32'(4 * i), 32'hA000_0000 + 32'(i), 0, 0, "fill");
    step(1, 32'd20, 32'hBAD0_0020, 0, 0, "full_push");
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 1, 0, "drain");
    step(0, 0, 0, 0, 0, "drained");

    // simultaneous push and pop at count 2
    step(1, 32'h100, 32'hC000_0001, 0, 0, "sim_fill");
    step(1, 32'h104, 32'hC000_0002, 0, 0, "sim_fill");
    for (int i = 0; i < 6; i++)
      step(1, 32'h108 + 32'(4 * i), 32'hC000_0003 + 32'(i), 1, 0, "sim");
    step(0, 0, 0, 0, 0, "sim_done");
    step(0, 0, 0, 1, 0, "sim_drain");
    step(0, 0, 0, 1, 0, "sim_drain");

    // flush with push and pop at count 3
    for (int i = 0; i < 3; i++)
      step(1, 32'h200 + 32'(4 * i), 32'hD000_0000 + 32'(i), 0, 0, "fl_fill");
    step(1, 32'hDEAD, 32'hDEADBEEF, 1, 1, "fl_hit");
    step(1, 32'h300, 32'hE000_0000, 0, 0, "fl_after");
    step(0, 0, 0, 1, 0, "fl_pop");

    // empty pop
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, "empty_pop");
    step(0, 0, 0, 0, 0, "empty_done");

    // async reset between edges at count 2
    step(1, 32'h400, 32'hF000_0000, 0, 0, "ar_fill");
    step(1, 32'h404, 32'hF000_0001, 0, 0, "ar_fill");
    @(negedge clk);
    chkState("ar_pre");
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    model.delete();
    chk("ar_count", longint'(count), 0);
    chk("ar_out_valid", longint'(out_valid), 0);
    chk("ar_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'd100, 32'h1234_5678, 0, 0, "ar_push");
    step(0, 0, 0, 0, 0, "ar_read");
    chk("ar_out_pc", longint'(out_pc), 100);
    m0 = dut.uMem.mem[0];
    chk("ar_entry0_pc", longint'(m0[2*WIDTH-1:WIDTH]), 100);
    step(0, 0, 0, 1, 0, "ar_pop");

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, "rand");
    while (model.size() != 0)
      step(0, 0, 0, 1, 0, "final_drain");
    step(0, 0, 0, 0, 0, "final");
    @(negedge clk);
    chk("scoreboard_empty", longint'(expQ.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of 2, minimum 2).
REQ-002 SHALL have parameter WIDTH, default 32, width of the pc and instruction fields.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, IF stage presents a fetched entry.
REQ-006 SHALL have port in_pc, input, WIDTH, pc+4 value from the IF stage.
REQ-007 SHALL have port in_instruction, input, WIDTH, fetched instruction word.
REQ-008 SHALL have port in_ready, output, 1, queue accepts an entry this cycle; the IF stage uses ~in_ready as its freeze.
REQ-009 SHALL have port flush, input, 1, branch taken; discard all queued entries.
REQ-010 SHALL have port out_ready, input, 1, ID stage consumes the head entry this cycle.
REQ-011 SHALL have port out_valid, output, 1, head entry valid.
REQ-012 SHALL have port out_pc, output, WIDTH, pc of the head entry.
REQ-013 SHALL have port out_instruction, output, WIDTH, instruction of the head entry.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, number of occupied entries.

Function
REQ-015 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-016 SHALL write {in_pc, in_instruction} at the tail and advance the tail pointer on push.
REQ-017 SHALL advance the head pointer on pop; entry contents are not cleared.
REQ-018 SHALL drive out_pc/out_instruction combinationally from the head entry; a pushed entry becomes visible one cycle after its push edge (latency 1, no bypass).
REQ-019 SHALL drive out_valid = (count != 0) and in_ready = (count != DEPTH), both derived from registered state only.
REQ-020 SHALL update count as count+1 on push only, count-1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-021 SHALL permit simultaneous push and pop at any occupancy strictly between 0 and DEPTH.
REQ-022 SHALL not accept a push when full, even if a pop occurs in the same cycle; in_ready is low.
REQ-023 SHALL ignore in_valid while in_ready is low, with no state change and no overwrite.
REQ-024 SHALL ignore out_ready while out_valid is low, with no underflow and count staying at 0.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH; pointers are log2(DEPTH) bits and count disambiguates full from empty.
REQ-026 SHALL, on flush, set head, tail and count to 0 at the next edge; flush overrides push and pop in the same cycle, and the in-flight entry is dropped.
REQ-027 SHALL have out_valid=0 and in_ready=1 in the cycle after a flush.

Reset
REQ-028 SHALL, while rst=0, asynchronously force head=0, tail=0, count=0, so that out_valid=0 and in_ready=1.
REQ-029 SHALL not reset storage contents; out_pc/out_instruction are don't-care while out_valid=0.
REQ-030 SHALL abandon any operation in progress when rst is asserted mid-operation; the first push after rst deassertion lands in entry 0.

Structure
REQ-031 SHALL place the DEPTH/WIDTH defaults and the entry type {pc, instruction} (2*WIDTH bits) in the shared pipeline package.
REQ-032 SHALL implement storage as one sub-module, if_queue_mem: a DEPTH x 2*WIDTH register array with synchronous write and asynchronous read, no reset.
REQ-033 SHALL keep pointer, count and handshake logic in if_id_queue.

Verification
REQ-034 SHALL verify basic flow: reset, then push pc=4/instr=0xE3A01005 -> next cycle out_valid=1, out_pc=4, out_instruction=0xE3A01005, count=1.
REQ-035 SHALL verify full: push 4 entries (pc 4, 8, 12, 16) with out_ready=0 -> in_ready=0, count=4; a 5th push with pc=20 is ignored; popping 4 times yields 4, 8, 12, 16 in order.
REQ-036 SHALL verify simultaneous push and pop: at count=2, push and pop together for 6 cycles -> count stays 2, pointers wrap, output order is preserved.
REQ-037 SHALL verify flush priority: at count=3, assert flush together with push and pop -> next cycle count=0, out_valid=0, in_ready=1, and the dropped entry never appears.
REQ-038 SHALL verify empty pop: at count=0 with out_ready=1 for 3 cycles -> count=0 and out_valid=0 throughout.
REQ-039 SHALL verify async reset: at count=2, assert rst=0 between clock edges -> count=0 and out_valid=0 immediately; after release, a push with pc=100 is read back from entry 0.
